// File: rtl/simon_key_schedule.sv
// simon_key_schedule: SIMON 32/64 round-key expansion, one key per cycle with per-key ready flags
module simon_key_schedule #(
  parameter int N_ROUNDS = 32,
  parameter logic [61:0] Z_SEQ = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_load,
  input  logic [63:0] master_key,
  output logic        busy,
  output logic        keys_done,
  output logic [15:0] key [0:N_ROUNDS-1],
  output logic        key_ready [0:N_ROUNDS-1]
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  state_t state, state_nx;
  logic [4:0] idx;
  logic [5:0] z_pos;
  logic [15:0] tmp, key_nx;
  logic load_ok;
  assign load_ok = key_load && state != EXPAND;
  assign z_pos = 6'd61 - ({1'b0, idx} - 6'd4);
  assign tmp = {key[idx - 5'd1][2:0], key[idx - 5'd1][15:3]} ^ key[idx - 5'd3];
  assign key_nx = 16'hFFFC ^ {15'b0, Z_SEQ[z_pos]} ^ key[idx - 5'd4] ^ tmp ^ {tmp[0], tmp[15:1]};
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next state: load starts expansion from IDLE or DONE, expansion ends after key 31
  always_comb
    state_nx = state == EXPAND ? (idx == 5'd31 ? DONE : EXPAND) : (key_load ? EXPAND : state);
  // status outputs decoded from the registered state
  always_comb begin
    busy = state == EXPAND;
    keys_done = state == DONE;
  end
  // key array, ready flags and write index; each flag rises on the edge that writes its key
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= 5'd4;
      for (int i = 0; i < N_ROUNDS; i++) begin
        key[i] <= '0;
        key_ready[i] <= 1'b0;
      end
    end else if (load_ok) begin
      idx <= 5'd4;
      for (int i = 0; i < 4; i++) key[i] <= master_key[16*i +: 16];
      for (int i = 0; i < N_ROUNDS; i++) key_ready[i] <= i < 4;
    end else if (state == EXPAND) begin
      key[idx] <= key_nx;
      key_ready[idx] <= 1'b1;
      idx <= idx == 5'd31 ? idx : idx + 5'd1;
    end
  end
endmodule

// File: doc/simon_key_schedule.md
# simon_key_schedule

Generates the 32 round keys of SIMON 32/64 from a 64-bit master key, one key per cycle. It drives the `key[31:0]` and `key_ready[31:0]` inputs of `encrypt_decrypt`. Each key becomes visible, with its ready flag, as soon as it is computed, so encryption can start on round 0 while expansion is still running. Decryption starts at round 31 and therefore waits for `keys_done`.

## Interface
Parameters:
- `N_ROUNDS`, 32: number of round keys; fixed for SIMON 32/64, exposed only for clarity.
- `Z_SEQ`, 62'b11111010001001010110000111001101111101000100101011000011100110: constant sequence z0. Bit index 0 is the leftmost character.

Ports:
- Clock and reset: clock `clk`; reset `rst`, synchronous, active-high.
- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous active-high reset.
- `key_load`, input, 1: single-cycle request to start expansion of `master_key`.
- `master_key`, input, 64: {k3,k2,k1,k0}; k0 = bits [15:0].
- `busy`, output, 1: high while expansion is in progress.
- `keys_done`, output, 1: level; high once all 32 keys are valid.
- `key`, output, [15:0] × [31:0] (unpacked): round key array.
- `key_ready`, output, 1 × [31:0] (unpacked): per-entry valid flag.

## Operation
- FSM states: IDLE, EXPAND, DONE.
- **IDLE**, on `key_load`=1:
  - Write key[0..3] = k0..k3.
  - Set key_ready[0..3].
  - Clear key_ready[4..31].
  - Set idx=4 and go to EXPAND.
- **EXPAND**, each cycle:
  - tmp = ROR16(key[idx-1],3) ^ key[idx-3].
  - key[idx] = 16'hFFFC ^ {15'b0, Z_SEQ[idx-4]} ^ key[idx-4] ^ tmp ^ ROR16(tmp,1).
  - Set key_ready[idx]; idx++.
  - After writing idx=31, go to DONE.
- **DONE**: hold all keys; `keys_done`=1; `busy`=0.
  - `key_load` in DONE behaves as in IDLE: clears flags 4..31, reloads 0..3, re-enters EXPAND.
- `key_load` during EXPAND is ignored. The current expansion completes unchanged.
- `master_key` is sampled only in the cycle `key_load` is accepted. Later changes have no effect.
- All arithmetic is 16-bit XOR/rotate; no carries. idx is a 5-bit counter, 4..31, and never wraps.
- `busy` = (state==EXPAND).
- `keys_done` = (state==DONE).
- key_ready[i] is set in the same edge that writes key[i]. A flag never rises before its key is stable.

## Timing
- Reset values: state=IDLE, idx=4, key[*]=16'h0000, key_ready[*]=0, busy=0, keys_done=0.
- Reset has priority over `key_load` in the same cycle.
- Reset mid-expansion clears everything on the next edge.
- Edge E0 samples `key_load`=1. After E0: key_ready[0..3]=1, busy=1.
- After edge E0+n (n=1..28): key_ready[3+n]=1.
- After E0+28: key[31] valid, state=DONE, keys_done=1, busy=0.
- Latency, load to all keys valid: 28 cycles.
- key_ready[r] rises no later than cycle r-3 after load. The encryptor consumes one round per cycle starting at round 0, so it never stalls after the first cycle.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:**
  - Hold `rst` for 2 cycles with `key_load`=1.
  - Required: all key_ready=0, key[*]=0, busy=0, keys_done=0.
- **Standard vector:**
  - Load 64'h1918_1110_0908_0100.
  - Required: key[0..3] = 0100, 0908, 1110, 1918.
  - Required: key[4]=16'h71C3 and key[5]=16'hB649.
  - Required: key[31] matches the golden SIMON 32/64 model; keys_done rises exactly 28 cycles after load.
  - Feeding the keys to `encrypt_decrypt` with plaintext 6565_6877 gives ciphertext C69B_E9BB.
- **Flag ordering:**
  - Monitor every cycle: key_ready[i] never 1 while key[i] differs from its final value.
  - Flags rise in order 4..31, one per cycle.
- **Load during EXPAND:**
  - Pulse `key_load` with a different key at cycle 10.
  - Required: ignored; final keys equal the first key's expansion.
- **Reload from DONE:**
  - After keys_done, load 64'h0.
  - Required: key_ready[4..31] drop to 0 on the next edge and keys_done=0.
  - Required: key[4] = 16'hFFFC^1^0 = 16'hFFFD.
- **Reset mid-operation:**
  - Assert `rst` at cycle 15 of expansion.
  - Required: all flags 0 and IDLE next edge; a subsequent load gives a correct full expansion.
